// File: rtl/fifomult2024_pkg.sv
// Shared types and helpers for the fifomult2024 result-accumulator slice.
package fifomult2024_pkg;

    localparam int PROD_W   = 32;
    localparam int ERRCNT_W = 8;

    typedef enum logic {
        S_ACC,
        S_EMIT
    } acc_state_t;

    // A product is good when its XOR-reduce matches the transmitted parity bit.
    function automatic logic even_parity_ok(input logic [PROD_W-1:0] data, input logic parity);
        return (^data) == parity;
    endfunction

endpackage

// File: rtl/fifomult2024_out_reg.sv
// Valid/ready holding register for batch sums: load-through when consumed, overrun when busy.
module fifomult2024_out_reg
    import fifomult2024_pkg::*;
#(
    parameter int unsigned ACC_W = 40
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear_i,
    input  logic                load_i,
    input  logic [ACC_W-1:0]    data_i,
    input  logic [ERRCNT_W-1:0] cnt_i,
    input  logic                ready_i,
    output logic [ACC_W-1:0]    data_o,
    output logic                parity_o,
    output logic [ERRCNT_W-1:0] cnt_o,
    output logic                valid_o,
    output logic                overrun_o
);

    logic [ACC_W-1:0]    data_q;
    logic                parity_q;
    logic [ERRCNT_W-1:0] cnt_q;
    logic                valid_q;
    logic                overrun_q;
    logic                free;

    assign free = !valid_q || ready_i;

    always_ff @(posedge clk) begin
        if (!rst_n || clear_i) begin
            data_q    <= '0;
            parity_q  <= 1'b0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else if (load_i) begin
            if (free) begin
                data_q   <= data_i;
                parity_q <= ^data_i;
                cnt_q    <= cnt_i;
                valid_q  <= 1'b1;
            end else begin
                // Busy: the new sum is dropped and the held one stays intact.
                overrun_q <= 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign data_o    = data_q;
    assign parity_o  = parity_q;
    assign cnt_o     = cnt_q;
    assign valid_o   = valid_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/fifomult2024_result_acc.sv
// Parity-checked batch accumulator for fifomult2024 products with a valid/ready sum output.
module fifomult2024_result_acc
    import fifomult2024_pkg::*;
#(
    parameter int unsigned N_ACC = 4,
    parameter int unsigned ACC_W = 40
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PROD_W-1:0]    data_in,
    input  logic                 data_in_parity,
    input  logic                 data_in_valid,
    input  logic                 flush,
    input  logic                 clear,
    output logic [ACC_W-1:0]     acc_out,
    output logic                 acc_out_parity,
    output logic [ERRCNT_W-1:0]  acc_out_cnt,
    output logic                 acc_out_valid,
    input  logic                 acc_out_ready,
    output logic [ERRCNT_W-1:0]  parity_err_cnt,
    output logic                 overrun_err
);

    acc_state_t          state_q;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [ERRCNT_W-1:0] cnt_q, cnt_d;
    logic [ERRCNT_W-1:0] perr_q, perr_d;
    logic                good, bad, emit;

    always_comb begin
        good = data_in_valid && even_parity_ok(data_in, data_in_parity);
        bad  = data_in_valid && !even_parity_ok(data_in, data_in_parity);
        emit = (state_q == S_EMIT);
        // acc_q holds the finished batch during S_EMIT, so the next batch starts from zero here.
        acc_d = emit ? '0 : acc_q;
        cnt_d = emit ? '0 : cnt_q;
        if (good) begin
            acc_d = acc_d + {{(ACC_W-PROD_W){data_in[PROD_W-1]}}, data_in};
            cnt_d = cnt_d + 1'b1;
        end
        perr_d = perr_q;
        if (bad && perr_q != '1) begin
            perr_d = perr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state_q <= S_ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
            perr_q  <= '0;
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            perr_q <= perr_d;
            case (state_q)
                S_ACC: begin
                    if (cnt_d == ERRCNT_W'(N_ACC) || (flush && cnt_d != '0)) begin
                        state_q <= S_EMIT;
                    end
                end
                default: state_q <= S_ACC;
            endcase
        end
    end

    fifomult2024_out_reg #(
        .ACC_W(ACC_W)
    ) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (clear),
        .load_i    (emit),
        .data_i    (acc_q),
        .cnt_i     (cnt_q),
        .ready_i   (acc_out_ready),
        .data_o    (acc_out),
        .parity_o  (acc_out_parity),
        .cnt_o     (acc_out_cnt),
        .valid_o   (acc_out_valid),
        .overrun_o (overrun_err)
    );

    assign parity_err_cnt = perr_q;

endmodule

// File: tb/tb_fifomult2024_result_acc.sv
// Bench for fifomult2024_result_acc: directed literal cases plus randomized traffic against a batch model.
module tb_fifomult2024_result_acc;

    localparam int unsigned N_ACC = 4;
    localparam int unsigned ACC_W = 40;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [31:0]      data_in = '0;
    logic             data_in_parity = 1'b0;
    logic             data_in_valid = 1'b0;
    logic             flush = 1'b0;
    logic             clear = 1'b0;
    logic [ACC_W-1:0] acc_out;
    logic             acc_out_parity;
    logic [7:0]       acc_out_cnt;
    logic             acc_out_valid;
    logic             acc_out_ready = 1'b1;
    logic [7:0]       parity_err_cnt;
    logic             overrun_err;

    fifomult2024_result_acc #(
        .N_ACC(N_ACC),
        .ACC_W(ACC_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_in        (data_in),
        .data_in_parity (data_in_parity),
        .data_in_valid  (data_in_valid),
        .flush          (flush),
        .clear          (clear),
        .acc_out        (acc_out),
        .acc_out_parity (acc_out_parity),
        .acc_out_cnt    (acc_out_cnt),
        .acc_out_valid  (acc_out_valid),
        .acc_out_ready  (acc_out_ready),
        .parity_err_cnt (parity_err_cnt),
        .overrun_err    (overrun_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Batch model: a finished batch is snapshotted and offered to the output one edge later.
    logic [ACC_W-1:0] m_acc = '0, m_bsum = '0, m_out = '0;
    int               m_cnt = 0, m_bcnt = 0, m_ocnt = 0, m_perr = 0;
    bit               m_valid = 0, m_ovr = 0, m_emit = 0;

    always @(posedge clk) begin
        bit was_emit;
        if (!rst_n || clear) begin
            m_acc = '0; m_bsum = '0; m_out = '0;
            m_cnt = 0; m_bcnt = 0; m_ocnt = 0; m_perr = 0;
            m_valid = 0; m_ovr = 0; m_emit = 0;
        end else begin
            if (m_emit) begin
                if (!m_valid || acc_out_ready) begin
                    m_out = m_bsum; m_ocnt = m_bcnt; m_valid = 1;
                end else begin
                    m_ovr = 1;
                end
            end else if (m_valid && acc_out_ready) begin
                m_valid = 0;
            end
            was_emit = m_emit;
            m_emit = 0;
            if (data_in_valid) begin
                if ((^data_in) == data_in_parity) begin
                    m_acc = m_acc + {{(ACC_W-32){data_in[31]}}, data_in};
                    m_cnt++;
                end else if (m_perr < 255) begin
                    m_perr++;
                end
            end
            if (!was_emit && (m_cnt == int'(N_ACC) || (flush && m_cnt > 0))) begin
                m_emit = 1; m_bsum = m_acc; m_bcnt = m_cnt; m_acc = '0; m_cnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid", 64'(acc_out_valid), 64'(m_valid));
            chk("acc_out", 64'(acc_out), 64'(m_out));
            chk("acc_cnt", 64'(acc_out_cnt), 64'(m_ocnt));
            chk("acc_par", 64'(acc_out_parity), 64'(^m_out));
            chk("perr", 64'(parity_err_cnt), 64'(m_perr));
            chk("overrun", 64'(overrun_err), 64'(m_ovr));
        end
    end

    task automatic cyc(input bit v, input logic [31:0] d, input bit bad, input bit fl, input bit cl);
        data_in_valid  = v;
        data_in        = d;
        data_in_parity = bad ? ~(^d) : (^d);
        flush          = fl;
        clear          = cl;
        @(posedge clk);
        #1;
        data_in_valid = 0; flush = 0; clear = 0;
    endtask

    task automatic good(input logic [31:0] d);
        cyc(1, d, 0, 0, 0);
    endtask

    task automatic idle();
        cyc(0, '0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle();
        rst_n = 1;
    endtask

    initial begin
        do_reset();
        chk_en = 1;
        chk("rst_valid", 64'(acc_out_valid), 64'd0);
        chk("rst_acc", 64'(acc_out), 64'd0);

        // 3, -5, 100, 2 -> 100, latency and single-cycle valid
        acc_out_ready = 1;
        good(32'd3); good(-32'sd5); good(32'd100); good(32'd2);
        chk("lat_early", 64'(acc_out_valid), 64'd0);
        idle();
        chk("t1_valid", 64'(acc_out_valid), 64'd1);
        chk("t1_acc", 64'(acc_out), 64'd100);
        chk("t1_cnt", 64'(acc_out_cnt), 64'd4);
        chk("t1_par", 64'(acc_out_parity), 64'(^32'd100));
        idle();
        chk("t1_drop", 64'(acc_out_valid), 64'd0);

        repeat (4) good(32'h7FFF_FFFF);
        idle();
        chk("max_pos", 64'(acc_out), 64'h01_FFFF_FFFC);
        repeat (4) good(32'h8000_0000);
        idle();
        chk("max_neg", 64'(acc_out), 64'hFE_0000_0000);
        idle();

        good(32'd10); good(32'd20); cyc(1, 32'd55, 1, 0, 0); cyc(0, '0, 0, 1, 0);
        idle();
        chk("fl_acc", 64'(acc_out), 64'd30);
        chk("fl_cnt", 64'(acc_out_cnt), 64'd2);
        chk("fl_perr", 64'(parity_err_cnt), 64'd1);
        repeat (260) cyc(1, $urandom, 1, 0, 0);
        chk("perr_sat", 64'(parity_err_cnt), 64'd255);

        acc_out_ready = 0;
        for (int i = 1; i <= 8; i++) good(32'(i));
        idle();
        chk("ovr_hold", 64'(acc_out), 64'd10);
        chk("ovr_valid", 64'(acc_out_valid), 64'd1);
        chk("ovr_flag", 64'(overrun_err), 64'd1);
        cyc(0, '0, 0, 0, 1);
        chk("clr_valid", 64'(acc_out_valid), 64'd0);
        chk("clr_ovr", 64'(overrun_err), 64'd0);
        chk("clr_perr", 64'(parity_err_cnt), 64'd0);
        chk("clr_cnt", 64'(acc_out_cnt), 64'd0);

        acc_out_ready = 1;
        good(32'd1); good(32'd2); cyc(1, 32'd7, 0, 1, 0);
        idle();
        chk("flsmp_acc", 64'(acc_out), 64'd10);
        chk("flsmp_cnt", 64'(acc_out_cnt), 64'd3);
        idle();
        cyc(0, '0, 0, 1, 0);
        idle();
        chk("fl_empty", 64'(acc_out_valid), 64'd0);

        good(32'd9); good(32'd9);
        do_reset();
        chk("mid_rst", 64'(acc_out_valid), 64'd0);
        good(32'd5); good(32'd6); good(32'd7); good(32'd8);
        idle();
        chk("post_rst", 64'(acc_out), 64'd26);
        acc_out_ready = 0;
        idle();
        repeat (4) good(32'd3);
        idle();
        do_reset();
        chk("vrst_valid", 64'(acc_out_valid), 64'd0);
        chk("vrst_acc", 64'(acc_out), 64'd0);
        acc_out_ready = 1;
        repeat (4) good(32'd1);
        idle();
        chk("post_vrst", 64'(acc_out), 64'd4);

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] d;
            int          r;
            r = $urandom_range(0, 9);
            d = (r == 0) ? 32'h7FFF_FFFF : (r == 1) ? 32'h8000_0000 : $urandom;
            acc_out_ready = ($urandom_range(0, 1) == 1);
            rst_n = ($urandom_range(0, 499) != 0);
            cyc($urandom_range(0, 99) < 60, d, $urandom_range(0, 99) < 10,
                !m_emit && ($urandom_range(0, 99) < 6), $urandom_range(0, 199) == 0);
        end
        rst_n = 1;
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
